// File: rtl/pe_pkg.sv
// Shared types and constants for the PE adder scheduler.
// State encoding, PE datapath width default and completed-op counter helpers.
package pe_pkg;

    localparam int PE_DATA_W = 8;
    localparam int OPCNT_W   = 16;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_e;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [OPCNT_W-1:0] sat_inc(input logic [OPCNT_W-1:0] val);
        return (val == {OPCNT_W{1'b1}}) ? val : val + OPCNT_W'(1);
    endfunction

endpackage

// File: rtl/pe_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping from NUM_REQ-1 back to 0, and reports one-hot grant plus index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int          pos;
        logic [ID_W-1:0] pos_w;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = 0;
        pos_w       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_w = ID_W'(pos);
            if (!grant_valid && req[pos_w]) begin
                grant[pos_w] = 1'b1;
                grant_idx    = pos_w;
                grant_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_add_scheduler.sv
// Time-shares one registered PE adder among NUM_REQ requesters: round-robin
// grant, operand capture, one-cycle issue, result capture and tagged response.
module pe_add_scheduler
    import pe_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = PE_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      pe_rst,
    output logic                      pe_en,
    output logic [DATA_W-1:0]         pe_a,
    output logic [DATA_W-1:0]         pe_b,
    input  logic [DATA_W-1:0]         pe_sum,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [OPCNT_W-1:0]        op_count
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     gnt_q, gnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [OPCNT_W-1:0]  op_count_q, op_count_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_valid;
    logic [DATA_W-1:0]   a_arr [NUM_REQ];
    logic [DATA_W-1:0]   b_arr [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*DATA_W +: DATA_W];
            b_arr[i] = req_b[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        op_count_d = op_count_q;
        req_ready  = '0;
        pe_rst     = 1'b0;
        pe_en      = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            // Gated by rst_n so the PE clear stays low while reset is held.
            CLEAR: begin
                pe_rst  = rst_n;
                state_d = IDLE;
            end
            IDLE: begin
                if (arb_valid) begin
                    req_ready = arb_grant;
                    a_d       = a_arr[arb_idx];
                    b_d       = b_arr[arb_idx];
                    gnt_d     = arb_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                pe_en   = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_data_d = pe_sum;
                rsp_id_d   = gnt_q;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rr_ptr_d   = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
                    op_count_d = sat_inc(op_count_q);
                    state_d    = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            op_count_q <= op_count_d;
        end
    end

    // PE operands are the captured registers, so they hold between issues.
    assign pe_a     = a_q;
    assign pe_b     = b_q;
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_pe_add_scheduler.sv
// Bench for pe_add_scheduler with a behavioural registered PE adder attached.
// Expected grants, sums and counts come from a simple round-robin reference model.
module tb_pe_add_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        pe_rst;
    logic        pe_en;
    logic [7:0]  pe_a;
    logic [7:0]  pe_b;
    logic [7:0]  pe_sum;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [15:0] op_count;

    int total_checks;
    int bad_checks;
    int model_ptr;
    int model_cnt;

    pe_add_scheduler #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .pe_rst    (pe_rst),
        .pe_en     (pe_en),
        .pe_a      (pe_a),
        .pe_b      (pe_b),
        .pe_sum    (pe_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered PE adder: sync clear, enable, truncating add.
    always @(posedge clk) begin
        if (pe_rst) begin
            pe_sum <= 8'd0;
        end else if (pe_en) begin
            pe_sum <= pe_a + pe_b;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int pickGrant(input logic [3:0] v, input int ptr);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (ptr + k) % 4;
            if (((v >> idx) & 4'd1) != 4'd0) begin
                return idx;
            end
        end
        return -1;
    endfunction

    // One full transaction (or one idle cycle when v is zero); starts and ends in IDLE.
    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b, input int stall);
        int         g;
        logic [7:0] ea, eb, es;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        #1;
        if (v == 4'd0) begin
            checkOutput("idle_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            return;
        end
        g  = pickGrant(v, model_ptr);
        ea = 8'(a >> (8 * g));
        eb = 8'(b >> (8 * g));
        es = 8'((int'(ea) + int'(eb)) % 256);
        checkOutput("grant_onehot", 32'(req_ready), 32'(1 << g));
        checkOutput("idle_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_a = $urandom;
        req_b = $urandom;
        #1;
        checkOutput("issue_en", 32'(pe_en), 32'd1);
        checkOutput("issue_a", 32'(pe_a), 32'(ea));
        checkOutput("issue_b", 32'(pe_b), 32'(eb));
        checkOutput("issue_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("capture_en", 32'(pe_en), 32'd0);
        checkOutput("capture_hold_a", 32'(pe_a), 32'(ea));
        checkOutput("capture_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_id", 32'(rsp_id), 32'(g));
        checkOutput("rsp_data", 32'(rsp_data), 32'(es));
        repeat (stall) begin
            @(negedge clk);
            #1;
            checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall_id", 32'(rsp_id), 32'(g));
            checkOutput("stall_data", 32'(rsp_data), 32'(es));
            checkOutput("stall_ready", 32'(req_ready), 32'd0);
            checkOutput("stall_count", 32'(op_count), 32'(model_cnt));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        model_ptr = (g + 1) % 4;
        if (model_cnt < 65535) begin
            model_cnt++;
        end
        #1;
        checkOutput("post_hs_valid", 32'(rsp_valid), 32'd0);
        checkOutput("op_count", 32'(op_count), 32'(model_cnt));
    endtask

    task automatic resetMidResp();
        req_valid = 4'b1000;
        req_a     = {8'd9, 24'd0};
        req_b     = {8'd5, 24'd0};
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("pre_reset_valid", 32'(rsp_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_op_count", 32'(op_count), 32'd0);
        checkOutput("reset_pe_rst", 32'(pe_rst), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
        req_valid = 4'd0;
        model_ptr = 0;
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("clear_pe_rst", 32'(pe_rst), 32'd1);
        checkOutput("clear_op_count", 32'(op_count), 32'd0);
        checkOutput("clear_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("clear_done", 32'(pe_rst), 32'd0);
        checkOutput("clear_no_rsp", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        model_ptr    = 0;
        model_cnt    = 0;
        req_valid    = 4'd0;
        req_a        = 32'd0;
        req_b        = 32'd0;
        rsp_ready    = 1'b0;
        rst_n        = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("por_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("por_pe_rst", 32'(pe_rst), 32'd0);
        checkOutput("por_pe_en", 32'(pe_en), 32'd0);
        checkOutput("por_pe_a", 32'(pe_a), 32'd0);
        checkOutput("por_op_count", 32'(op_count), 32'd0);
        checkOutput("por_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("por_clear_pulse", 32'(pe_rst), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("por_clear_end", 32'(pe_rst), 32'd0);

        $display("[TB] round-robin with all requesters valid");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 0);
        end

        $display("[TB] single op and overflow");
        applyStimulus(4'b0001, {24'd0, 8'd20}, {24'd0, 8'd22}, 0);
        applyStimulus(4'b0001, {24'd0, 8'd200}, {24'd0, 8'd100}, 0);

        $display("[TB] backpressure and sparse wrap");
        applyStimulus(4'b0100, {8'd0, 8'd255, 16'd0}, {8'd0, 8'd255, 16'd0}, 10);
        applyStimulus(4'b0010, {16'd0, 8'd77, 8'd0}, {16'd0, 8'd11, 8'd0}, 0);
        applyStimulus(4'b1111, $urandom, $urandom, 1);
        applyStimulus(4'b0000, 32'd0, 32'd0, 0);
        applyStimulus(4'b0000, 32'd0, 32'd0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] reset during response");
        resetMidResp();
        applyStimulus(4'b0110, {8'd0, 8'd128, 8'd1, 8'd0}, {8'd0, 8'd128, 8'd2, 8'd0}, 0);
        applyStimulus(4'b0110, {8'd0, 8'd128, 8'd1, 8'd0}, {8'd0, 8'd128, 8'd2, 8'd0}, 2);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
